// File: rtl/rggen_rtl_pkg.sv
// rtl/rggen_rtl_pkg.sv - shared register-bus types for rggen blocks
package rggen_rtl_pkg;

  typedef enum logic {
    RGGEN_READ  = 1'b0,
    RGGEN_WRITE = 1'b1
  } rggen_access;

  typedef enum logic [1:0] {
    RGGEN_OKAY   = 2'b00,
    RGGEN_EXOKAY = 2'b01,
    RGGEN_SLVERR = 2'b10,
    RGGEN_DECERR = 2'b11
  } rggen_status;

  typedef enum logic [1:0] {
    IDLE,
    INDEX,
    DATA,
    RESP
  } rggen_indirect_seq_state_e;

endpackage

// File: rtl/rggen_indirect_access_sequencer.sv
// rtl/rggen_indirect_access_sequencer.sv - index write + data access sequencer with index cache
module rggen_indirect_access_sequencer
  import rggen_rtl_pkg::*;
#(
  parameter int                     ADDRESS_WIDTH   = 8,
  parameter int                     BUS_WIDTH       = 32,
  parameter int                     INDEX_WIDTH     = 8,
  parameter bit [ADDRESS_WIDTH-1:0] INDEX_ADDRESS   = 'h00,
  parameter bit [ADDRESS_WIDTH-1:0] DATA_ADDRESS    = 'h04,
  parameter bit                     SKIP_SAME_INDEX = 1'b1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic                     i_req_write,
  input  logic [INDEX_WIDTH-1:0]   i_req_index,
  input  logic [BUS_WIDTH-1:0]     i_req_data,
  input  logic [BUS_WIDTH-1:0]     i_req_strobe,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output rggen_status              o_rsp_status,
  output logic [BUS_WIDTH-1:0]     o_rsp_data,
  input  logic                     i_index_invalidate,
  output logic                     o_bus_valid,
  output rggen_access              o_bus_access,
  output logic [ADDRESS_WIDTH-1:0] o_bus_address,
  output logic [BUS_WIDTH-1:0]     o_bus_write_data,
  output logic [BUS_WIDTH-1:0]     o_bus_strobe,
  input  logic                     i_bus_ready,
  input  rggen_status              i_bus_status,
  input  logic [BUS_WIDTH-1:0]     i_bus_read_data
);

  if ((INDEX_WIDTH > BUS_WIDTH) || (INDEX_ADDRESS == DATA_ADDRESS)) begin : g_invalid_params
    $error("rggen_indirect_access_sequencer: INDEX_WIDTH must fit BUS_WIDTH and addresses must differ");
  end

  rggen_indirect_seq_state_e state;
  rggen_indirect_seq_state_e state_next;

  logic                   req_write;
  logic [INDEX_WIDTH-1:0] req_index;
  logic [BUS_WIDTH-1:0]   req_data;
  logic [BUS_WIDTH-1:0]   req_strobe;

  logic                   cache_valid;
  logic [INDEX_WIDTH-1:0] cache_index;

  logic                   accept;
  logic                   hit;
  logic                   bus_ok;
  logic                   index_done;
  logic                   data_done;
  logic                   data_write;
  logic [BUS_WIDTH-1:0]   data_wdata;
  logic [BUS_WIDTH-1:0]   data_strobe;

  assign accept     = (state == IDLE) && i_req_valid;
  assign hit        = SKIP_SAME_INDEX && cache_valid && (cache_index == i_req_index);
  assign bus_ok     = (i_bus_status == RGGEN_OKAY);
  assign index_done = (state == INDEX) && i_bus_ready;
  assign data_done  = (state == DATA) && i_bus_ready;

  assign o_req_ready = (state == IDLE);
  assign o_rsp_valid = (state == RESP);
  assign o_bus_valid = (state == INDEX) || (state == DATA);

  // State register; reset abandons any in-flight access without a response
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  // Sequencing: a cache hit goes straight to the data access, an index error skips it
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_req_valid) state_next = hit ? DATA : INDEX;
      INDEX:   if (i_bus_ready) state_next = bus_ok ? DATA : RESP;
      DATA:    if (i_bus_ready) state_next = RESP;
      RESP:    if (i_rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Data-access payload comes straight from the request port when issued from IDLE
  always_comb begin
    data_write  = req_write;
    data_wdata  = req_data;
    data_strobe = req_strobe;
    if (state == IDLE) begin
      data_write  = i_req_write;
      data_wdata  = i_req_data;
      data_strobe = i_req_strobe;
    end
  end

  // Capture the host request so the data access can follow the index write
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      req_write  <= 1'b0;
      req_index  <= '0;
      req_data   <= '0;
      req_strobe <= '0;
    end else if (accept) begin
      req_write  <= i_req_write;
      req_index  <= i_req_index;
      req_data   <= i_req_data;
      req_strobe <= i_req_strobe;
    end
  end

  // Registered bus payload; only reloaded when a new access starts, so it holds during wait states
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_bus_access     <= RGGEN_READ;
      o_bus_address    <= '0;
      o_bus_write_data <= '0;
      o_bus_strobe     <= '0;
    end else if (accept && !hit) begin
      o_bus_access     <= RGGEN_WRITE;
      o_bus_address    <= INDEX_ADDRESS;
      o_bus_write_data <= BUS_WIDTH'(i_req_index);
      o_bus_strobe     <= '1;
    end else if ((accept && hit) || (index_done && bus_ok)) begin
      o_bus_access     <= data_write ? RGGEN_WRITE : RGGEN_READ;
      o_bus_address    <= DATA_ADDRESS;
      o_bus_write_data <= data_write ? data_wdata : '0;
      o_bus_strobe     <= data_write ? data_strobe : '0;
    end
  end

  // Index cache; invalidation wins over a same-cycle successful index write
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cache_valid <= 1'b0;
      cache_index <= '0;
    end else begin
      if (index_done && bus_ok) cache_index <= req_index;
      if (i_index_invalidate)   cache_valid <= 1'b0;
      else if (index_done)      cache_valid <= bus_ok;
    end
  end

  // Response capture: read data only survives an OKAY read
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rsp_status <= RGGEN_OKAY;
      o_rsp_data   <= '0;
    end else if (index_done && !bus_ok) begin
      o_rsp_status <= i_bus_status;
      o_rsp_data   <= '0;
    end else if (data_done) begin
      o_rsp_status <= i_bus_status;
      o_rsp_data   <= (bus_ok && !req_write) ? i_bus_read_data : '0;
    end
  end

endmodule

// File: tb/tb_rggen_indirect_access_sequencer.sv
// tb/tb_rggen_indirect_access_sequencer.sv - self-checking bench with transaction-level model
module tb_rggen_indirect_access_sequencer;
  import rggen_rtl_pkg::*;

  logic        clk;
  logic        i_rst;
  logic        i_req_valid, o_req_ready, i_req_write;
  logic [7:0]  i_req_index;
  logic [31:0] i_req_data, i_req_strobe;
  logic        o_rsp_valid, i_rsp_ready;
  rggen_status o_rsp_status;
  logic [31:0] o_rsp_data;
  logic        i_index_invalidate;
  logic        o_bus_valid;
  rggen_access o_bus_access;
  logic [7:0]  o_bus_address;
  logic [31:0] o_bus_write_data, o_bus_strobe;
  logic        i_bus_ready;
  rggen_status i_bus_status;
  logic [31:0] i_bus_read_data;

  rggen_indirect_access_sequencer #(
    .ADDRESS_WIDTH(8), .BUS_WIDTH(32), .INDEX_WIDTH(8),
    .INDEX_ADDRESS(8'h00), .DATA_ADDRESS(8'h04), .SKIP_SAME_INDEX(1'b1)
  ) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_write(i_req_write),
    .i_req_index(i_req_index), .i_req_data(i_req_data), .i_req_strobe(i_req_strobe),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_status(o_rsp_status),
    .o_rsp_data(o_rsp_data), .i_index_invalidate(i_index_invalidate),
    .o_bus_valid(o_bus_valid), .o_bus_access(o_bus_access), .o_bus_address(o_bus_address),
    .o_bus_write_data(o_bus_write_data), .o_bus_strobe(o_bus_strobe),
    .i_bus_ready(i_bus_ready), .i_bus_status(i_bus_status), .i_bus_read_data(i_bus_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    rggen_access acc;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic [31:0] st;
  } acc_t;

  function automatic acc_t index_access(input logic [7:0] idx);
    acc_t e;
    e.acc = RGGEN_WRITE; e.addr = 8'h00; e.wd = {24'h0, idx}; e.st = 32'hFFFF_FFFF;
    return e;
  endfunction

  function automatic acc_t data_access(input bit w, input logic [31:0] d, input logic [31:0] s);
    acc_t e;
    e.acc = w ? RGGEN_WRITE : RGGEN_READ; e.addr = 8'h04;
    e.wd = w ? d : 32'h0; e.st = w ? s : 32'h0;
    return e;
  endfunction

  // bus responder configuration (written by main thread only)
  int          bus_wait = 0;
  bit          rand_bus = 0;
  logic [31:0] fix_rdata = 32'h0;
  int          err_seq = 0;

  initial begin : bus_responder
    int cnt, cur, err_done, r;
    bit active;
    i_bus_ready = 1'b0; i_bus_status = RGGEN_OKAY; i_bus_read_data = 32'h0;
    cnt = 0; cur = 0; active = 0; err_done = 0;
    forever begin
      @(posedge clk); #1;
      i_bus_ready = 1'b0;
      if (i_rst || !o_bus_valid) active = 0;
      else begin
        if (!active) begin
          active = 1; cnt = 0;
          cur = rand_bus ? int'($urandom_range(0, 2)) : bus_wait;
        end
        if (cnt >= cur) begin
          i_bus_ready = 1'b1; active = 0;
          if (rand_bus) begin
            r = int'($urandom_range(0, 7));
            i_bus_status = (r < 6) ? RGGEN_OKAY : (r == 6) ? RGGEN_SLVERR : RGGEN_DECERR;
            i_bus_read_data = $urandom;
          end else begin
            if (err_done != err_seq) begin
              i_bus_status = RGGEN_SLVERR; err_done = err_seq;
            end else i_bus_status = RGGEN_OKAY;
            i_bus_read_data = fix_rdata;
          end
        end else cnt++;
      end
    end
  end

  // behavioural model state (owned by the compare process)
  bit          m_busy = 0, m_rsp_known = 0, m_cache_valid = 0;
  logic [7:0]  m_cache_idx = 0;
  bit          m_w;
  logic [7:0]  m_idx;
  logic [31:0] m_d, m_s;
  rggen_status m_rsp_st;
  logic [31:0] m_rsp_data;
  acc_t        m_acc_q[$];
  acc_t        bus_log[$];

  // compare process: checks every cycle against the model, then advances the model
  always @(negedge clk) begin
    acc_t e;
    if (i_rst) begin
      chk("rst_req_ready", o_req_ready, 1);
      chk("rst_rsp_valid", o_rsp_valid, 0);
      chk("rst_bus_valid", o_bus_valid, 0);
      chk("rst_bus_address", o_bus_address, 0);
      chk("rst_bus_wdata", o_bus_write_data, 0);
      chk("rst_bus_strobe", o_bus_strobe, 0);
      chk("rst_rsp_data", o_rsp_data, 0);
      m_busy = 0; m_rsp_known = 0; m_cache_valid = 0; m_cache_idx = 0;
      m_acc_q.delete();
    end else begin
      chk("req_ready", o_req_ready, !m_busy);
      chk("rsp_valid", o_rsp_valid, m_rsp_known);
      if (m_rsp_known) begin
        chk("rsp_status", o_rsp_status, m_rsp_st);
        chk("rsp_data", o_rsp_data, m_rsp_data);
      end
      chk("bus_valid", o_bus_valid, m_acc_q.size() != 0);
      if (m_acc_q.size() != 0) begin
        e = m_acc_q[0];
        chk("bus_access", o_bus_access, e.acc);
        chk("bus_address", o_bus_address, e.addr);
        chk("bus_wdata", o_bus_write_data, e.wd);
        chk("bus_strobe", o_bus_strobe, e.st);
      end
      if (o_bus_valid && i_bus_ready && m_acc_q.size() != 0) begin
        e = m_acc_q.pop_front();
        bus_log.push_back({o_bus_access, o_bus_address, o_bus_write_data, o_bus_strobe});
        if (e.addr == 8'h00) begin
          if (i_bus_status == RGGEN_OKAY) begin
            m_cache_valid = 1; m_cache_idx = m_idx;
            m_acc_q.push_back(data_access(m_w, m_d, m_s));
          end else begin
            m_cache_valid = 0; m_rsp_known = 1; m_rsp_st = i_bus_status; m_rsp_data = 0;
          end
        end else begin
          m_rsp_known = 1; m_rsp_st = i_bus_status;
          m_rsp_data = (i_bus_status == RGGEN_OKAY && !m_w) ? i_bus_read_data : 32'h0;
        end
      end
      if (o_rsp_valid && i_rsp_ready && m_rsp_known) begin
        m_rsp_known = 0; m_busy = 0;
      end
      if (i_req_valid && o_req_ready && !m_busy) begin
        m_w = i_req_write; m_idx = i_req_index; m_d = i_req_data; m_s = i_req_strobe;
        if (m_cache_valid && m_cache_idx == m_idx) m_acc_q.push_back(data_access(m_w, m_d, m_s));
        else m_acc_q.push_back(index_access(m_idx));
        m_busy = 1;
      end
      if (i_index_invalidate) m_cache_valid = 0;
    end
  end

  // one host transaction; inv_cycle selects the cycle (0 = accept cycle) that pulses invalidate
  task automatic do_req(input bit w, input logic [7:0] idx, input logic [31:0] d,
                        input logic [31:0] s, input int rsp_wait, input int inv_cycle,
                        output int lat, output rggen_status st, output logic [31:0] rd);
    int n;
    lat = -1; st = RGGEN_OKAY; rd = 32'h0;
    i_req_valid = 1; i_req_write = w; i_req_index = idx; i_req_data = d; i_req_strobe = s;
    i_index_invalidate = (inv_cycle == 0);
    n = 0;
    while (!o_req_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!o_req_ready) begin
      chk("req_accept_timeout", 0, 1);
      i_req_valid = 0; i_index_invalidate = 0;
      return;
    end
    @(posedge clk); #1;
    i_req_valid = 0; i_req_write = $urandom; i_req_index = $urandom;
    i_req_data = $urandom; i_req_strobe = $urandom;
    n = 1;
    i_index_invalidate = (inv_cycle == 1);
    while (!o_rsp_valid && n < 200) begin
      @(posedge clk); #1; n++;
      i_index_invalidate = (inv_cycle == n);
    end
    i_index_invalidate = 0;
    if (!o_rsp_valid) begin
      chk("rsp_timeout", 0, 1);
      return;
    end
    lat = n; st = o_rsp_status; rd = o_rsp_data;
    repeat (rsp_wait) begin @(posedge clk); #1; end
    i_rsp_ready = 1; @(posedge clk); #1; i_rsp_ready = 0;
  endtask

  task automatic pulse_invalidate();
    i_index_invalidate = 1; @(posedge clk); #1; i_index_invalidate = 0;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int lat, base, n;
    rggen_status st;
    logic [31:0] rd;
    i_rst = 1; i_req_valid = 0; i_req_write = 0; i_req_index = 0; i_req_data = 0;
    i_req_strobe = 0; i_rsp_ready = 0; i_index_invalidate = 0;
    repeat (3) @(posedge clk);
    #1 i_rst = 0;
    @(posedge clk); #1;

    // 1: write miss
    base = bus_log.size();
    do_req(1, 8'd3, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 0, -1, lat, st, rd);
    chk("t1_lat", lat, 3);
    chk("t1_status", st, RGGEN_OKAY);
    chk("t1_rdata", rd, 0);
    chk("t1_nacc", bus_log.size() - base, 2);
    if (bus_log.size() - base == 2) begin
      chk("t1_idx_access", bus_log[base], {RGGEN_WRITE, 8'h00, 32'h3, 32'hFFFF_FFFF});
      chk("t1_data_access", bus_log[base+1], {RGGEN_WRITE, 8'h04, 32'hA5A5_A5A5, 32'hFFFF_FFFF});
    end

    // 2: read hit
    fix_rdata = 32'h1234;
    base = bus_log.size();
    do_req(0, 8'd3, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 0, -1, lat, st, rd);
    chk("t2_lat", lat, 2);
    chk("t2_rdata", rd, 32'h1234);
    chk("t2_nacc", bus_log.size() - base, 1);
    if (bus_log.size() - base == 1)
      chk("t2_data_access", bus_log[base], {RGGEN_READ, 8'h04, 32'h0, 32'h0});

    // 3: index write error
    err_seq++;
    base = bus_log.size();
    do_req(1, 8'd9, 32'h5555_0000, 32'hFFFF_FFFF, 1, -1, lat, st, rd);
    chk("t3_lat", lat, 2);
    chk("t3_status", st, RGGEN_SLVERR);
    chk("t3_rdata", rd, 0);
    chk("t3_nacc", bus_log.size() - base, 1);
    base = bus_log.size();
    do_req(0, 8'd3, 32'h0, 32'h0, 0, -1, lat, st, rd);
    chk("t3_reissue_lat", lat, 3);
    if (bus_log.size() > base) chk("t3_reissue_addr", bus_log[base].addr, 8'h00);

    // 4: invalidation
    pulse_invalidate();
    base = bus_log.size();
    do_req(0, 8'd3, 32'h0, 32'h0, 0, -1, lat, st, rd);
    chk("t4_inv_lat", lat, 3);
    if (bus_log.size() > base) chk("t4_inv_wdata", bus_log[base].wd, 32'h3);
    do_req(0, 8'd5, 32'h0, 32'h0, 0, 1, lat, st, rd);
    chk("t4_inv_at_index_lat", lat, 3);
    do_req(0, 8'd5, 32'h0, 32'h0, 0, -1, lat, st, rd);
    chk("t4_after_override_lat", lat, 3);
    do_req(0, 8'd5, 32'h0, 32'h0, 0, 0, lat, st, rd);
    chk("t4_same_cycle_idle_lat", lat, 2);
    do_req(0, 8'd5, 32'h0, 32'h0, 0, -1, lat, st, rd);
    chk("t4_after_idle_inv_lat", lat, 3);

    // 5: wait states on bus and response
    do_req(0, 8'd3, 32'h0, 32'h0, 0, -1, lat, st, rd);
    bus_wait = 4;
    do_req(1, 8'd3, 32'h0F0F_1234, 32'h00FF_00FF, 3, -1, lat, st, rd);
    chk("t5_lat", lat, 6);
    bus_wait = 0;

    // 6: reset during DATA
    do_req(0, 8'd3, 32'h0, 32'h0, 0, -1, lat, st, rd);
    bus_wait = 20;
    i_req_valid = 1; i_req_write = 0; i_req_index = 8'd3;
    @(posedge clk); #1;
    i_req_valid = 0;
    chk("t6_in_data_valid", o_bus_valid, 1);
    chk("t6_in_data_addr", o_bus_address, 8'h04);
    #2 i_rst = 1;
    #1;
    chk("t6_async_bus_valid", o_bus_valid, 0);
    chk("t6_async_rsp_valid", o_rsp_valid, 0);
    @(posedge clk); #1;
    i_rst = 0; bus_wait = 0;
    repeat (3) begin @(posedge clk); #1; end
    base = bus_log.size();
    do_req(0, 8'd3, 32'h0, 32'h0, 0, -1, lat, st, rd);
    chk("t6_after_rst_lat", lat, 3);
    if (bus_log.size() > base) chk("t6_after_rst_addr", bus_log[base].addr, 8'h00);

    // randomized traffic against the model
    rand_bus = 1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0) pulse_invalidate();
      n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
      do_req(1'($urandom), 8'($urandom_range(0, 3)), $urandom, $urandom,
             int'($urandom_range(0, 2)), n, lat, st, rd);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    rand_bus = 0;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
